conn_setup_sequencer: RTL and testbench

CONN_SETUP_SEQUENCER -- requirements
Module: conn_setup_sequencer

---
 rtl/conn_setup_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_conn_setup_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conn_setup_sequencer.sv
// Connection setup sequencer: turns one open/close descriptor into a burst of
// setup frames, then waits (bounded) for the connection manager's status.
module conn_setup_sequencer #(
  parameter int NIC_ID         = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  // Descriptor handshake: a descriptor transfers on any clk edge where
  // req_valid and req_ready are both high; req_ready is only high in IDLE.
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_open,
  input  logic [31:0] req_conn_id,
  input  logic [31:0] req_dest_ip,
  input  logic [31:0] req_dest_port,
  input  logic [31:0] req_client_flow_id,
  input  logic [15:0] req_qp_num,
  input  logic [15:0] req_p_key,
  input  logic [31:0] req_q_key,
  output logic        setup_en_out,
  output logic [2:0]  setup_cmd_out,
  output logic [31:0] setup_data_out,
  output logic [63:0] setup_big_data_out,
  input  logic        status_valid_in,
  input  logic        status_error_in,
  output logic        done_valid,
  output logic        done_error,
  output logic        done_timeout,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("conn_setup_sequencer[%0d]: TIMEOUT_CYCLES=%0d outside 2..65535",
           NIC_ID, TIMEOUT_CYCLES);
  end

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_EMIT        = 2'd1,
    ST_WAIT_STATUS = 2'd2,
    ST_DONE        = 2'd3
  } state_t;

  localparam logic [2:0] CMD_CONN_ID   = 3'd0;
  localparam logic [2:0] CMD_OPEN      = 3'd1;
  localparam logic [2:0] CMD_DEST_IPV4 = 3'd2;
  localparam logic [2:0] CMD_DEST_PORT = 3'd3;
  localparam logic [2:0] CMD_FLOW_ID   = 3'd4;
  localparam logic [2:0] CMD_QP_FIELDS = 3'd5;
  localparam logic [2:0] CMD_ENABLE    = 3'd6;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_req_ready;
  logic [2:0]  r_idx;
  logic [15:0] r_wait_cnt;
  logic        r_done_error;
  logic        r_done_timeout;

  logic        r_open;
  logic [31:0] r_conn_id;
  logic [31:0] r_dest_ip;
  logic [31:0] r_dest_port;
  logic [31:0] r_flow_id;
  logic [15:0] r_qp_num;
  logic [15:0] r_p_key;
  logic [31:0] r_q_key;

  logic        w_accept;
  logic        w_last_frame;
  logic        w_timeout_hit;
  logic [2:0]  w_cmd;
  logic [31:0] w_data;
  logic [63:0] w_big;

  assign w_accept      = req_valid && r_req_ready;
  assign w_last_frame  = r_open ? (r_idx == 3'd6) : (r_idx == 3'd2);
  assign w_timeout_hit = (r_wait_cnt == TO_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        if (w_last_frame) w_state_nxt = ST_WAIT_STATUS;
      end
      ST_WAIT_STATUS: begin
        if (status_valid_in || w_timeout_hit) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // req_ready is registered so it stays low through reset and rises on the
  // first edge after release, and one cycle after DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= (w_state_nxt == ST_IDLE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx          <= 3'd0;
      r_wait_cnt     <= 16'd0;
      r_done_error   <= 1'b0;
      r_done_timeout <= 1'b0;
      r_open         <= 1'b0;
      r_conn_id      <= 32'd0;
      r_dest_ip      <= 32'd0;
      r_dest_port    <= 32'd0;
      r_flow_id      <= 32'd0;
      r_qp_num       <= 16'd0;
      r_p_key        <= 16'd0;
      r_q_key        <= 32'd0;
    end else begin
      if (r_state == ST_IDLE && w_accept) begin
        r_idx       <= 3'd0;
        r_open      <= req_open;
        r_conn_id   <= req_conn_id;
        r_dest_ip   <= req_dest_ip;
        r_dest_port <= req_dest_port;
        r_flow_id   <= req_client_flow_id;
        r_qp_num    <= req_qp_num;
        r_p_key     <= req_p_key;
        r_q_key     <= req_q_key;
      end
      if (r_state == ST_EMIT) r_idx <= r_idx + 3'd1;

      if (r_state == ST_EMIT) begin
        r_wait_cnt <= 16'd0;
      end else if (r_state == ST_WAIT_STATUS && !status_valid_in) begin
        r_wait_cnt <= r_wait_cnt + 16'd1;
      end

      // A status in the timeout cycle wins: it is a real answer.
      if (r_state == ST_WAIT_STATUS && w_state_nxt == ST_DONE) begin
        r_done_error   <= status_valid_in ? status_error_in : 1'b1;
        r_done_timeout <= !status_valid_in;
      end
    end
  end

  always_comb begin
    w_cmd  = 3'd0;
    w_data = 32'd0;
    w_big  = 64'd0;
    if (r_state == ST_EMIT) begin
      if (r_open) begin
        w_cmd = r_idx;
      end else begin
        case (r_idx)
          3'd0:    w_cmd = CMD_CONN_ID;
          3'd1:    w_cmd = CMD_OPEN;
          default: w_cmd = CMD_ENABLE;
        endcase
      end
      case (w_cmd)
        CMD_CONN_ID:   w_data = r_conn_id;
        CMD_OPEN:      w_data = {31'd0, r_open};
        CMD_DEST_IPV4: w_data = r_dest_ip;
        CMD_DEST_PORT: w_data = r_dest_port;
        CMD_FLOW_ID:   w_data = r_flow_id;
        CMD_QP_FIELDS: w_big  = {r_qp_num, r_p_key, r_q_key};
        default:       w_data = 32'd0;
      endcase
    end
  end

  assign req_ready          = r_req_ready;
  assign setup_en_out       = (r_state == ST_EMIT);
  assign setup_cmd_out      = w_cmd;
  assign setup_data_out     = w_data;
  assign setup_big_data_out = w_big;
  assign done_valid         = (r_state == ST_DONE);
  assign done_error         = done_valid & r_done_error;
  assign done_timeout       = done_valid & r_done_timeout;
  assign busy               = (r_state != ST_IDLE);
  assign dbg_state          = r_state;

endmodule

// File: tb/tb_conn_setup_sequencer.sv
// Bench for conn_setup_sequencer: frame-queue reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_conn_setup_sequencer;
  localparam int TO = 4;

  typedef struct packed {
    logic        open;
    logic [31:0] conn_id;
    logic [31:0] dest_ip;
    logic [31:0] dest_port;
    logic [31:0] flow;
    logic [15:0] qp;
    logic [15:0] pkey;
    logic [31:0] qkey;
  } desc_t;

  typedef struct packed {
    logic [2:0]  cmd;
    logic [31:0] data;
    logic [63:0] big;
  } fr_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  desc_t       drv = '0;
  logic        status_valid_in = 1'b0;
  logic        status_error_in = 1'b0;
  logic        req_ready, setup_en_out, done_valid, done_error, done_timeout, busy;
  logic [2:0]  setup_cmd_out;
  logic [31:0] setup_data_out;
  logic [63:0] setup_big_data_out;
  logic [1:0]  dbg_state;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conn_setup_sequencer #(.NIC_ID(0), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_open(drv.open),
    .req_conn_id(drv.conn_id), .req_dest_ip(drv.dest_ip),
    .req_dest_port(drv.dest_port), .req_client_flow_id(drv.flow),
    .req_qp_num(drv.qp), .req_p_key(drv.pkey), .req_q_key(drv.qkey),
    .setup_en_out(setup_en_out), .setup_cmd_out(setup_cmd_out),
    .setup_data_out(setup_data_out), .setup_big_data_out(setup_big_data_out),
    .status_valid_in(status_valid_in), .status_error_in(status_error_in),
    .done_valid(done_valid), .done_error(done_error),
    .done_timeout(done_timeout), .busy(busy), .dbg_state(dbg_state)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  fr_t m_fq[$];
  bit  m_ready = 0, m_wait = 0, m_done = 0, m_derr = 0, m_dto = 0;
  int  m_wcnt = 0;

  function automatic void push_frames(desc_t d);
    m_fq.push_back(fr_t'{3'd0, d.conn_id, 64'd0});
    m_fq.push_back(fr_t'{3'd1, {31'd0, d.open}, 64'd0});
    if (d.open) begin
      m_fq.push_back(fr_t'{3'd2, d.dest_ip, 64'd0});
      m_fq.push_back(fr_t'{3'd3, d.dest_port, 64'd0});
      m_fq.push_back(fr_t'{3'd4, d.flow, 64'd0});
      m_fq.push_back(fr_t'{3'd5, 32'd0, {d.qp, d.pkey, d.qkey}});
    end
    m_fq.push_back(fr_t'{3'd6, 32'd0, 64'd0});
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_fq.delete();
      m_ready = 0; m_wait = 0; m_done = 0; m_wcnt = 0;
    end else if (m_done) begin
      m_done = 0; m_ready = 1;
    end else if (m_fq.size() > 0) begin
      void'(m_fq.pop_front());
      if (m_fq.size() == 0) begin m_wait = 1; m_wcnt = 0; end
    end else if (m_wait) begin
      if (status_valid_in) begin
        m_done = 1; m_derr = status_error_in; m_dto = 0; m_wait = 0;
      end else if (m_wcnt == TO - 1) begin
        m_done = 1; m_derr = 1; m_dto = 1; m_wait = 0;
      end else begin
        m_wcnt++;
      end
    end else if (m_ready && req_valid) begin
      push_frames(drv);
      m_ready = 0;
    end else begin
      m_ready = 1;
    end
  end

  // ---------------- compare + log ----------------
  int          lg_cyc[$];
  logic [2:0]  lg_cmd[$];
  logic [31:0] lg_data[$];
  logic [63:0] lg_big[$];
  int          dn_cyc[$];
  bit          dn_err[$];
  bit          dn_to[$];

  always @(negedge clk) begin : compare
    fr_t f;
    f = (m_fq.size() > 0) ? m_fq[0] : '0;
    check("req_ready", {63'd0, req_ready}, {63'd0, m_ready});
    check("busy", {63'd0, busy}, {63'd0, (m_fq.size() > 0) || m_wait || m_done});
    check("setup_en", {63'd0, setup_en_out}, {63'd0, m_fq.size() > 0});
    check("setup_cmd", {61'd0, setup_cmd_out}, {61'd0, f.cmd});
    check("setup_data", {32'd0, setup_data_out}, {32'd0, f.data});
    check("setup_big", setup_big_data_out, f.big);
    check("done_valid", {63'd0, done_valid}, {63'd0, m_done});
    check("done_error", {63'd0, done_error}, {63'd0, m_done && m_derr});
    check("done_timeout", {63'd0, done_timeout}, {63'd0, m_done && m_dto});
    if (reset_n && setup_en_out) begin
      lg_cyc.push_back(cyc); lg_cmd.push_back(setup_cmd_out);
      lg_data.push_back(setup_data_out); lg_big.push_back(setup_big_data_out);
    end
    if (reset_n && done_valid) begin
      dn_cyc.push_back(cyc); dn_err.push_back(done_error); dn_to.push_back(done_timeout);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    lg_cyc.delete(); lg_cmd.delete(); lg_data.delete(); lg_big.delete();
    dn_cyc.delete(); dn_err.delete(); dn_to.delete();
  endtask

  task automatic wait_hs(output int t);
    t = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin t = cyc; break; end
    end
    if (t < 0) begin
      n_chk++; n_fail++;
      $display("FAIL handshake_wait: req_ready never seen, expected within 200 cycles");
    end
  endtask

  task automatic send(input desc_t d, output int t);
    @(posedge clk); #1;
    drv = d; req_valid = 1'b1;
    wait_hs(t);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic status_at(input int target, input logic err);
    bit hit = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (cyc == target) begin hit = 1; break; end
    end
    status_valid_in = hit; status_error_in = err;
    @(posedge clk); #1;
    status_valid_in = 1'b0; status_error_in = 1'b0;
    check("status_slot_reached", {63'd0, hit}, 64'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : stim
    int t, t2;
    desc_t d;

    // reset and release
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    check("rst_ready_before_edge", {63'd0, req_ready}, 64'd0);
    @(posedge clk); #1;
    check("rst_ready_after_edge", {63'd0, req_ready}, 64'd1);

    // open request
    clear_logs();
    d = '{open: 1'b1, conn_id: 32'd5, dest_ip: 32'h0A000001, dest_port: 32'd80,
          flow: 32'd3, qp: 16'h0012, pkey: 16'hFFFF, qkey: 32'h0000ABCD};
    send(d, t);
    status_at(t + 10, 1'b0);
    idle_cycles(3);
    check("open_frame_count", 64'(lg_cyc.size()), 64'd7);
    for (int i = 0; i < 7; i++) begin
      check("open_frame_cmd", {61'd0, lg_cmd[i]}, 64'(i));
      check("open_frame_cycle", 64'(lg_cyc[i]), 64'(t + 1 + i));
    end
    check("open_conn_data", {32'd0, lg_data[0]}, 64'd5);
    check("open_ip_data", {32'd0, lg_data[2]}, 64'h0A000001);
    check("open_qp_big", lg_big[5], 64'h0012FFFF0000ABCD);
    check("open_done_cycle", 64'(dn_cyc[0]), 64'(t + 11));
    check("open_done_err", {63'd0, dn_err[0]}, 64'd0);

    // close request, status error=1
    clear_logs();
    d = '{open: 1'b0, conn_id: 32'd9, dest_ip: 32'hDEADBEEF, dest_port: 32'd443,
          flow: 32'd7, qp: 16'h1234, pkey: 16'h5678, qkey: 32'h9ABCDEF0};
    send(d, t);
    status_at(t + 5, 1'b1);
    idle_cycles(3);
    check("close_frame_count", 64'(lg_cyc.size()), 64'd3);
    check("close_cmd0", {61'd0, lg_cmd[0]}, 64'd0);
    check("close_cmd1", {61'd0, lg_cmd[1]}, 64'd1);
    check("close_cmd2", {61'd0, lg_cmd[2]}, 64'd6);
    check("close_data0", {32'd0, lg_data[0]}, 64'd9);
    check("close_data1", {32'd0, lg_data[1]}, 64'd0);
    check("close_last_cycle", 64'(lg_cyc[2]), 64'(t + 3));
    check("close_done_cycle", 64'(dn_cyc[0]), 64'(t + 6));
    check("close_done_err", {63'd0, dn_err[0]}, 64'd1);

    // timeout: WAIT_STATUS entered at t+4, done 4 cycles later
    clear_logs();
    d = '0; d.conn_id = 32'h11;
    send(d, t);
    idle_cycles(12);
    check("to_done_count", 64'(dn_cyc.size()), 64'd1);
    check("to_done_cycle", 64'(dn_cyc[0]), 64'(t + 8));
    check("to_done_err", {63'd0, dn_err[0]}, 64'd1);
    check("to_done_timeout", {63'd0, dn_to[0]}, 64'd1);

    // status in the same cycle the counter reaches TO-1
    clear_logs();
    d = '0; d.conn_id = 32'h22;
    send(d, t);
    status_at(t + 7, 1'b1);
    idle_cycles(3);
    check("sim_done_cycle", 64'(dn_cyc[0]), 64'(t + 8));
    check("sim_done_err", {63'd0, dn_err[0]}, 64'd1);
    check("sim_done_timeout", {63'd0, dn_to[0]}, 64'd0);

    // reset after the 3rd open frame
    clear_logs();
    d = '{open: 1'b1, conn_id: 32'h44, dest_ip: 32'hC0A80001, dest_port: 32'd22,
          flow: 32'd1, qp: 16'h0001, pkey: 16'h8001, qkey: 32'h11111111};
    send(d, t);
    for (int i = 0; i < 10 && cyc != t + 3; i++) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_en_low", {63'd0, setup_en_out}, 64'd0);
    check("abort_busy_low", {63'd0, busy}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    check("abort_ready_low", {63'd0, req_ready}, 64'd0);
    @(posedge clk); #1;
    check("abort_ready_high", {63'd0, req_ready}, 64'd1);
    idle_cycles(12);
    check("abort_frame_count", 64'(lg_cyc.size()), 64'd3);
    check("abort_no_done", 64'(dn_cyc.size()), 64'd0);

    // stray status in EMIT, second descriptor held valid throughout
    clear_logs();
    d = '{open: 1'b1, conn_id: 32'h31, dest_ip: 32'h01020304, dest_port: 32'd8080,
          flow: 32'd9, qp: 16'h00AA, pkey: 16'h7FFF, qkey: 32'h00C0FFEE};
    @(posedge clk); #1;
    drv = d; req_valid = 1'b1;
    wait_hs(t);
    @(posedge clk); #1;
    drv = '0; drv.conn_id = 32'h32;
    status_valid_in = 1'b1; status_error_in = 1'b0;
    @(posedge clk); #1;
    status_valid_in = 1'b0;
    wait_hs(t2);
    @(posedge clk); #1;
    req_valid = 1'b0;
    idle_cycles(12);
    check("b2b_frame_count", 64'(lg_cyc.size()), 64'd10);
    check("b2b_done_count", 64'(dn_cyc.size()), 64'd2);
    check("stray_ignored_cycle", 64'(dn_cyc[0]), 64'(t + 12));
    check("stray_ignored_timeout", {63'd0, dn_to[0]}, 64'd1);
    check("b2b_accept_cycle", 64'(t2), 64'(dn_cyc[0] + 1));
    check("b2b_second_conn", {32'd0, lg_data[7]}, 64'h32);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
